poison_field: RTL and testbench

//  Manages N_POISON independent poison items on the snake-game grid, replacing the single fixed poison.

---
 rtl/poison_field.sv | 190 +++++++++++++++++++
 tb/tb_poison_field.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poison_field.sv
// poison_field: N_POISON independent poison items for the snake-game grid.
//
// Each slot cycles ACTIVE -> DEAD -> PLACE -> ACTIVE.
// - ACTIVE: the slot is on the board. If the head lands on it while the game
//   is in PLAY_STATE, the slot is parked off-board and a respawn countdown starts.
// - DEAD: the countdown moves only on PLAY-state ticks.
// - PLACE: the slot waits for a free cell. The candidate cell comes from a free-running LFSR.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   state, tick       game FSM state and one-cycle game-step strobe
//   head_x, head_y    snake head cell
//   food_x, food_y    food cell (never chosen for placement)
//   poison_x/_y       packed slot coordinates, slot i at [i*COORD_W +: COORD_W]
//   poison_active     per-slot on-board/lethal flag
//   touch_poison      one-cycle pulse after the head hits an active slot
//   touch_idx         lowest index of the slot hit, valid with touch_poison
//
// All outputs come straight from registers.
module poison_field #(
    parameter int unsigned N_POISON      = 4,
    parameter int unsigned COORD_W       = 4,
    parameter int unsigned GRID_W        = 12,
    parameter int unsigned GRID_H        = 12,
    parameter logic [2:0]  PLAY_STATE    = 3'b010,
    parameter int unsigned PARK_XY       = 13,
    parameter int unsigned INIT_X        = 5,
    parameter int unsigned INIT_Y        = 3,
    parameter int unsigned RESPAWN_TICKS = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [2:0]                  state,
    input  logic                        tick,
    input  logic [COORD_W-1:0]          head_x,
    input  logic [COORD_W-1:0]          head_y,
    input  logic [COORD_W-1:0]          food_x,
    input  logic [COORD_W-1:0]          food_y,
    output logic [N_POISON*COORD_W-1:0] poison_x,
    output logic [N_POISON*COORD_W-1:0] poison_y,
    output logic [N_POISON-1:0]         poison_active,
    output logic                        touch_poison,
    output logic [2:0]                  touch_idx
);

    localparam int unsigned        CNT_W   = $clog2(RESPAWN_TICKS + 1);
    localparam int unsigned        CW1     = COORD_W + 1;
    localparam logic [COORD_W-1:0] PARK    = COORD_W'(PARK_XY);
    localparam logic [COORD_W-1:0] HOME_X  = COORD_W'(INIT_X);
    localparam logic [CW1-1:0]     GRID_WL = CW1'(GRID_W);
    localparam logic [CW1-1:0]     GRID_HL = CW1'(GRID_H);
    localparam logic [CNT_W-1:0]   RESPAWN = CNT_W'(RESPAWN_TICKS);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        StActive,
        StDead,
        StPlace
    } slot_st_e;

    // Slot state
    slot_st_e           st_q  [N_POISON];
    logic [COORD_W-1:0] x_q   [N_POISON];
    logic [COORD_W-1:0] y_q   [N_POISON];
    logic [CNT_W-1:0]   cnt_q [N_POISON];
    logic [15:0]        lfsr_q;
    logic               touch_q;
    logic [2:0]         touch_idx_q;

    // Next-cycle decisions
    logic                play;
    logic [N_POISON-1:0] hit;
    logic                hit_any;
    logic [2:0]          hit_idx;
    logic                place_any;
    logic [2:0]          place_idx;
    logic [COORD_W-1:0]  cand_x;
    logic [COORD_W-1:0]  cand_y;
    logic                cand_busy;
    logic                cand_in_grid;
    logic                place_ok;
    logic                lfsr_fb;

    // Taps 16,14,13,11. A nonzero seed never reaches the all-zero state.
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_comb begin
        play      = (state == PLAY_STATE);
        hit       = '0;
        hit_any   = 1'b0;
        hit_idx   = '0;
        place_any = 1'b0;
        place_idx = '0;
        cand_busy = 1'b0;
        cand_x    = lfsr_q[COORD_W-1:0];
        cand_y    = lfsr_q[2*COORD_W-1:COORD_W];

        for (int i = 0; i < int'(N_POISON); i++) begin
            hit[i] = play && (st_q[i] == StActive) &&
                     (x_q[i] == head_x) && (y_q[i] == head_y);
            if ((st_q[i] == StActive) && (x_q[i] == cand_x) && (y_q[i] == cand_y)) begin
                cand_busy = 1'b1;
            end
        end

        // Scan downward so the lowest index wins.
        for (int i = int'(N_POISON) - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any = 1'b1;
                hit_idx = 3'(i);
            end
            if (st_q[i] == StPlace) begin
                place_any = 1'b1;
                place_idx = 3'(i);
            end
        end

        cand_in_grid = ({1'b0, cand_x} < GRID_WL) && ({1'b0, cand_y} < GRID_HL);
        place_ok     = play && place_any && cand_in_grid && !cand_busy &&
                       !((cand_x == head_x) && (cand_y == head_y)) &&
                       !((cand_x == food_x) && (cand_y == food_y));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q      <= LFSR_SEED;
            touch_q     <= 1'b0;
            touch_idx_q <= '0;
            for (int i = 0; i < int'(N_POISON); i++) begin
                st_q[i]  <= StActive;
                x_q[i]   <= HOME_X;
                y_q[i]   <= COORD_W'(INIT_Y + 2 * i);
                cnt_q[i] <= '0;
            end
        end else begin
            lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
            touch_q <= hit_any;
            if (hit_any) begin
                touch_idx_q <= hit_idx;
            end
            for (int i = 0; i < int'(N_POISON); i++) begin
                case (st_q[i])
                    StActive: begin
                        if (hit[i]) begin
                            st_q[i]  <= StDead;
                            x_q[i]   <= PARK;
                            y_q[i]   <= PARK;
                            cnt_q[i] <= RESPAWN;
                        end
                    end
                    StDead: begin
                        if (play && tick) begin
                            cnt_q[i] <= cnt_q[i] - 1'b1;
                            if (cnt_q[i] == CNT_ONE) begin
                                st_q[i] <= StPlace;
                            end
                        end
                    end
                    StPlace: begin
                        // Only the lowest-index waiting slot is served each cycle.
                        if (place_ok && (place_idx == 3'(i))) begin
                            st_q[i] <= StActive;
                            x_q[i]  <= cand_x;
                            y_q[i]  <= cand_y;
                        end
                    end
                    default: begin
                        st_q[i] <= StActive;
                    end
                endcase
            end
        end
    end

    always_comb begin
        poison_x      = '0;
        poison_y      = '0;
        poison_active = '0;
        for (int i = 0; i < int'(N_POISON); i++) begin
            poison_x[i*COORD_W +: COORD_W] = x_q[i];
            poison_y[i*COORD_W +: COORD_W] = y_q[i];
            poison_active[i]               = (st_q[i] == StActive);
        end
    end

    assign touch_poison = touch_q;
    assign touch_idx    = touch_idx_q;

endmodule

// File: tb/tb_poison_field.sv
// Bench for poison_field.
// A slot-level model (alive flag, ticks left, position) is stepped once per clock.
// Directed scenarios and a randomized run are both checked against this model.
module tb_poison_field;

    localparam int         NP   = 4;
    localparam int         GW   = 12;
    localparam int         GH   = 12;
    localparam int         RT   = 8;
    localparam logic [3:0] PARK = 4'd13;
    localparam logic [2:0] PLAY = 3'b010;
    localparam logic [3:0] OFFX = 4'd15;
    localparam logic [3:0] OFFY = 4'd14;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  state = 3'b000;
    logic        tick = 1'b0;
    logic [3:0]  head_x = OFFX, head_y = OFFX, food_x = OFFX, food_y = OFFY;
    logic [15:0] poison_x, poison_y;
    logic [3:0]  poison_active;
    logic        touch_poison;
    logic [2:0]  touch_idx;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model
    logic [15:0] m_lfsr;
    logic [3:0]  m_x [NP];
    logic [3:0]  m_y [NP];
    bit          m_act [NP];
    int          m_left [NP];
    logic        m_touch;
    logic [2:0]  m_idx;

    always #5 clk = ~clk;

    poison_field #(
        .N_POISON(4), .COORD_W(4), .GRID_W(12), .GRID_H(12), .PLAY_STATE(3'b010),
        .PARK_XY(13), .INIT_X(5), .INIT_Y(3), .RESPAWN_TICKS(8), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .state(state), .tick(tick),
        .head_x(head_x), .head_y(head_y), .food_x(food_x), .food_y(food_y),
        .poison_x(poison_x), .poison_y(poison_y), .poison_active(poison_active),
        .touch_poison(touch_poison), .touch_idx(touch_idx)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [15:0] exp_px();
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) r[i*4 +: 4] = m_x[i];
        return r;
    endfunction

    function automatic logic [15:0] exp_py();
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) r[i*4 +: 4] = m_y[i];
        return r;
    endfunction

    function automatic logic [3:0] exp_act();
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) r[i] = m_act[i];
        return r;
    endfunction

    // Returns 1 if the current candidate cell would be accepted, ignoring the head.
    function automatic bit cand_clear_but_head();
        logic [3:0] cx, cy;
        bit ok;
        cx = m_lfsr[3:0];
        cy = m_lfsr[7:4];
        ok = (int'(cx) < GW) && (int'(cy) < GH) && !(cx == food_x && cy == food_y);
        for (int j = 0; j < NP; j++)
            if (m_act[j] && m_x[j] == cx && m_y[j] == cy) ok = 0;
        return ok;
    endfunction

    function automatic bit cand_on_active();
        bit r;
        r = 0;
        for (int j = 0; j < NP; j++)
            if (m_act[j] && m_x[j] == m_lfsr[3:0] && m_y[j] == m_lfsr[7:4]) r = 1;
        return r;
    endfunction

    task automatic model_reset();
        m_lfsr  = 16'hACE1;
        m_touch = 1'b0;
        m_idx   = 3'd0;
        for (int i = 0; i < NP; i++) begin
            m_x[i]    = 4'd5;
            m_y[i]    = 4'(3 + 2 * i);
            m_act[i]  = 1;
            m_left[i] = 0;
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit         play, ok;
        bit         hit [NP];
        int         first, pick;
        logic [3:0] cx, cy;
        play  = (state == PLAY);
        first = -1;
        pick  = -1;
        for (int i = 0; i < NP; i++) begin
            hit[i] = play && m_act[i] && m_x[i] == head_x && m_y[i] == head_y;
            if (hit[i] && first < 0) first = i;
            if (!m_act[i] && m_left[i] == 0 && pick < 0) pick = i;
        end
        cx = m_lfsr[3:0];
        cy = m_lfsr[7:4];
        ok = play && pick >= 0 && int'(cx) < GW && int'(cy) < GH &&
             !(cx == head_x && cy == head_y) && !(cx == food_x && cy == food_y);
        for (int j = 0; j < NP; j++)
            if (m_act[j] && m_x[j] == cx && m_y[j] == cy) ok = 0;
        for (int i = 0; i < NP; i++) begin
            if (hit[i]) begin
                m_act[i]  = 0;
                m_x[i]    = PARK;
                m_y[i]    = PARK;
                m_left[i] = RT;
            end else if (!m_act[i] && m_left[i] > 0 && play && tick) begin
                m_left[i] = m_left[i] - 1;
            end
        end
        if (ok) begin
            m_act[pick] = 1;
            m_x[pick]   = cx;
            m_y[pick]   = cy;
        end
        m_touch = (first >= 0);
        if (first >= 0) m_idx = 3'(first);
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (poison_x !== 16'h5555) begin
            n_bad++; $display("FAIL reset_x: got %h want 5555", poison_x);
        end
        n_cmp++;
        if (poison_y !== 16'h9753) begin
            n_bad++; $display("FAIL reset_y: got %h want 9753", poison_y);
        end
        n_cmp++;
        if (poison_active !== 4'b1111) begin
            n_bad++; $display("FAIL reset_active: got %b want 1111", poison_active);
        end
        n_cmp++;
        if (touch_poison !== 1'b0 || touch_idx !== 3'd0) begin
            n_bad++; $display("FAIL reset_touch: got %b/%0d want 0/0", touch_poison, touch_idx);
        end
    endtask

    task automatic test_hit();
        state = PLAY; head_x = 4'd5; head_y = 4'd5;
        step();
        head_x = OFFX; head_y = OFFX;
        n_cmp++;
        if (touch_poison !== 1'b1 || touch_idx !== 3'd1) begin
            n_bad++; $display("FAIL hit_touch: got %b/%0d want 1/1", touch_poison, touch_idx);
        end
        n_cmp++;
        if (poison_x !== 16'h55D5 || poison_y !== 16'h97D3) begin
            n_bad++; $display("FAIL hit_park: got %h/%h want 55d5/97d3", poison_x, poison_y);
        end
        n_cmp++;
        if (poison_active !== 4'b1101) begin
            n_bad++; $display("FAIL hit_active: got %b want 1101", poison_active);
        end
        step();
        n_cmp++;
        if (touch_poison !== 1'b0) begin
            n_bad++; $display("FAIL hit_pulse_width: got %b want 0", touch_poison);
        end
    endtask

    task automatic test_respawn_count();
        state = PLAY;
        for (int k = 0; k < 7; k++) begin
            tick = 1'b1;
            step();
            n_cmp++;
            if (poison_active !== exp_act() || poison_x !== exp_px()) begin
                n_bad++;
                $display("FAIL respawn_tick%0d: got %b/%h want %b/%h", k, poison_active, poison_x,
                         exp_act(), exp_px());
            end
        end
        state = 3'b000;
        for (int k = 0; k < 3; k++) step();
        tick = 1'b0; state = PLAY;
        for (int k = 0; k < 10; k++) step();
        n_cmp++;
        if (poison_active[1] !== 1'b0) begin
            n_bad++; $display("FAIL respawn_still_dead: got %b want 0", poison_active[1]);
        end
        tick = 1'b1;
        step();
        tick = 1'b0; state = 3'b000;
        n_cmp++;
        if (poison_active !== 4'b1101 || poison_y !== 16'h97D3) begin
            n_bad++; $display("FAIL respawn_enter_place: got %b/%h want 1101/97d3",
                              poison_active, poison_y);
        end
    endtask

    task automatic test_placement();
        int guard;
        // Candidate on the head
        guard = 0;
        while (!cand_clear_but_head() && guard < 3000) begin step(); guard++; end
        n_cmp++;
        if (guard >= 3000) begin
            n_bad++; $display("FAIL place_head_search: got timeout want candidate");
        end
        head_x = m_lfsr[3:0]; head_y = m_lfsr[7:4]; state = PLAY;
        step();
        state = 3'b000; head_x = OFFX; head_y = OFFX;
        n_cmp++;
        if (poison_active[1] !== 1'b0 || touch_poison !== 1'b0) begin
            n_bad++; $display("FAIL place_reject_head: got %b/%b want 0/0", poison_active[1], touch_poison);
        end
        // Candidate on the food
        guard = 0;
        while (!cand_clear_but_head() && guard < 3000) begin step(); guard++; end
        food_x = m_lfsr[3:0]; food_y = m_lfsr[7:4]; state = PLAY;
        step();
        state = 3'b000; food_x = OFFX; food_y = OFFY;
        n_cmp++;
        if (poison_active[1] !== 1'b0) begin
            n_bad++; $display("FAIL place_reject_food: got %b want 0", poison_active[1]);
        end
        // Candidate on another active slot
        guard = 0;
        while (!cand_on_active() && guard < 5000) begin step(); guard++; end
        n_cmp++;
        if (guard >= 5000) begin
            n_bad++; $display("FAIL place_slot_search: got timeout want candidate");
        end
        state = PLAY;
        step();
        n_cmp++;
        if (poison_active[1] !== 1'b0) begin
            n_bad++; $display("FAIL place_reject_slot: got %b want 0", poison_active[1]);
        end
        // Free run until accepted
        guard = 0;
        while (poison_active[1] !== 1'b1 && guard < 200) begin
            step();
            guard++;
            n_cmp++;
            if (poison_x !== exp_px() || poison_y !== exp_py() || poison_active !== exp_act()) begin
                n_bad++;
                $display("FAIL place_run: got %h/%h/%b want %h/%h/%b", poison_x, poison_y,
                         poison_active, exp_px(), exp_py(), exp_act());
            end
        end
        n_cmp++;
        if (int'(poison_x[7:4]) >= GW || int'(poison_y[7:4]) >= GH ||
            (poison_x[7:4] == 4'd5 && (poison_y[7:4] == 4'd3 || poison_y[7:4] == 4'd7 ||
                                       poison_y[7:4] == 4'd9)) || guard >= 200) begin
            n_bad++; $display("FAIL place_cell: got (%0d,%0d) want free in-grid cell",
                              poison_x[7:4], poison_y[7:4]);
        end
    endtask

    task automatic test_hold();
        int pulses;
        pulses = 0;
        state = PLAY; head_x = 4'd5; head_y = 4'd3;
        for (int k = 0; k < 5; k++) begin
            step();
            if (touch_poison === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 1 || touch_idx !== 3'd0) begin
            n_bad++; $display("FAIL hold_one_pulse: got %0d/%0d want 1/0", pulses, touch_idx);
        end
        pulses = 0;
        state = 3'b000; head_x = 4'd5; head_y = 4'd7;
        for (int k = 0; k < 5; k++) begin
            step();
            if (touch_poison === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0 || poison_active[2] !== 1'b1) begin
            n_bad++; $display("FAIL hold_idle_no_hit: got %0d/%b want 0/1", pulses, poison_active[2]);
        end
        head_x = OFFX; head_y = OFFX;
    endtask

    task automatic test_reset_mid();
        state = PLAY; tick = 1'b1;
        for (int k = 0; k < 4; k++) step();
        tick = 1'b0; head_x = 4'd5; head_y = 4'd7;
        step();
        head_x = OFFX; head_y = OFFX; tick = 1'b1;
        for (int k = 0; k < 4; k++) step();
        tick = 1'b0; state = 3'b000;
        reset = 1'b0;
        #1;
        test_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        int k;
        for (int c = 0; c < 3000; c++) begin
            state  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : PLAY;
            tick   = ($urandom_range(0, 2) == 0);
            food_x = 4'($urandom_range(0, 15));
            food_y = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, NP - 1);
                head_x = m_x[k]; head_y = m_y[k];
            end else begin
                head_x = 4'($urandom_range(0, 15));
                head_y = 4'($urandom_range(0, 15));
            end
            step();
            n_cmp++;
            if (poison_x !== exp_px() || poison_y !== exp_py() || poison_active !== exp_act() ||
                touch_poison !== m_touch || touch_idx !== m_idx) begin
                n_bad++;
                $display("FAIL random_c%0d: got %h/%h/%b/%b/%0d want %h/%h/%b/%b/%0d", c,
                         poison_x, poison_y, poison_active, touch_poison, touch_idx,
                         exp_px(), exp_py(), exp_act(), m_touch, m_idx);
            end
        end
    endtask

    initial begin
        model_reset();
        #22;
        reset = 1'b1;
        test_reset();
        test_hit();
        test_respawn_count();
        test_placement();
        test_hold();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
